bcd_display_scan: RTL and testbench

- Reads the six BCD digits produced by the frequency counter chain, together with its carry-out overflow.
- Captures them into a hold register on a latch strobe from the gate controller.
- Drives a time-multiplexed 6-digit common-anode 7-segment display with a blanking gap between digits.
- Sits between the counter chain and the board display pins; runs entirely on the system clock.

---
 rtl/bcd_display_scan.sv | 148 ++++++++++++++
 tb/tb_bcd_display_scan.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Captures six BCD digits plus overflow and scans them onto a 6-digit common-anode
// 7-segment display with a blanking gap. Optional: LEADING_ZERO_BLANK_EN.
module bcd_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int DP_POS       = 6
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       latch,
    input  logic       ovf,
    input  logic [3:0] led_0,
    input  logic [3:0] led_1,
    input  logic [3:0] led_2,
    input  logic [3:0] led_3,
    input  logic [3:0] led_4,
    input  logic [3:0] led_5,
    output logic [7:0] seg_n,
    output logic [5:0] dig_n,
    output logic       data_valid
);

    typedef enum logic {SHOW, BLANK} phase_t;

    localparam logic [15:0] SHOW_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
    localparam logic [2:0]  DP_IDX     = 3'(DP_POS);

    phase_t          phase;
    logic [2:0]      idx;
    logic [15:0]     cnt;
    logic [5:0][3:0] hold_digits;
    logic            hold_ovf;

    logic [3:0]      digit_val;
    logic [7:0]      show_seg;
    logic [2:0]      next_idx;

    function automatic logic [7:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 8'hC0;
            4'd1:    decode = 8'hF9;
            4'd2:    decode = 8'hA4;
            4'd3:    decode = 8'hB0;
            4'd4:    decode = 8'h99;
            4'd5:    decode = 8'h92;
            4'd6:    decode = 8'h82;
            4'd7:    decode = 8'hF8;
            4'd8:    decode = 8'h80;
            4'd9:    decode = 8'h90;
            default: decode = 8'hBF;
        endcase
    endfunction

    // NOTE: the hold register is reset explicitly so the display reads 0 until the first capture.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hold_digits <= '0;
            hold_ovf    <= 1'b0;
            data_valid  <= 1'b0;
        end else if (latch) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            hold_digits <= {led_5, led_4, led_3, led_2, led_1, led_0};
            hold_ovf    <= ovf;
            data_valid  <= 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // lead_zero[i] is set when digits i..5 are all zero; upper bits pad the 3-bit index.
    logic [7:0] lead_zero;

    always_comb begin
        lead_zero    = '0;
        lead_zero[5] = (hold_digits[5] == 4'd0);
        for (int i = 4; i >= 0; i--)
            lead_zero[i] = lead_zero[i+1] && (hold_digits[i] == 4'd0);
    end
`endif

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        digit_val = 4'd0;
        case (idx)
            3'd0:    digit_val = hold_digits[0];
            3'd1:    digit_val = hold_digits[1];
            3'd2:    digit_val = hold_digits[2];
            3'd3:    digit_val = hold_digits[3];
            3'd4:    digit_val = hold_digits[4];
            3'd5:    digit_val = hold_digits[5];
            default: digit_val = 4'd0;
        endcase

        show_seg = hold_ovf ? 8'hBF : decode(digit_val);
`ifdef LEADING_ZERO_BLANK_EN
        if (!hold_ovf && idx != 3'd0 && lead_zero[idx])
            show_seg = 8'hFF;
`endif
        if (idx == DP_IDX)
            show_seg[7] = 1'b0;

        next_idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end

    // Scan FSM with the display pins registered one clock behind the state.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            phase <= SHOW;
            idx   <= 3'd0;
            cnt   <= 16'd0;
            seg_n <= 8'hFF;
            dig_n <= 6'h3F;
        end else begin
            if (phase == SHOW) begin
                dig_n <= ~(6'b1 << idx);
                seg_n <= show_seg;
            end else begin
                dig_n <= 6'h3F;
                seg_n <= 8'hFF;
            end

            case (phase)
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt <= 16'd0;
                        if (BLANK_CYCLES > 0)
                            phase <= BLANK;
                        else
                            idx <= next_idx;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= 16'd0;
                        phase <= SHOW;
                        idx   <= next_idx;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: phase <= SHOW;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan (SCAN_DIV=4, BLANK_CYCLES=1, DP_POS=3);
// follows LEADING_ZERO_BLANK_EN for the leading-zero expectations.
module tb_bcd_display_scan;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int DP_POS       = 3;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       latch = 1'b0;
    logic       ovf   = 1'b0;
    logic [3:0] led_0 = '0, led_1 = '0, led_2 = '0, led_3 = '0, led_4 = '0, led_5 = '0;
    logic [7:0] seg_n;
    logic [5:0] dig_n;
    logic       data_valid;

    int passed = 0;
    int total  = 0;

    bcd_display_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .DP_POS      (DP_POS)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .latch     (latch),
        .ovf       (ovf),
        .led_0     (led_0),
        .led_1     (led_1),
        .led_2     (led_2),
        .led_3     (led_3),
        .led_4     (led_4),
        .led_5     (led_5),
        .seg_n     (seg_n),
        .dig_n     (dig_n),
        .data_valid(data_valid)
    );

    always #5 clock = ~clock;

    task automatic check_out(input string tag, input logic [5:0] dig, input logic [7:0] seg);
        total++;
        assert (dig_n === dig && seg_n === seg) passed++;
        else $error("FAIL %s: got dig_n=%h seg_n=%h, want dig_n=%h seg_n=%h",
                    tag, dig_n, seg_n, dig, seg);
    endtask

    task automatic check_dv(input string tag, input logic dv);
        total++;
        assert (data_valid === dv) passed++;
        else $error("FAIL %s: got data_valid=%b, want %b", tag, data_valid, dv);
    endtask

    // One clock: outputs are sampled on the falling edge.
    task automatic step(input string tag, input logic [5:0] dig, input logic [7:0] seg);
        @(negedge clock);
        check_out(tag, dig, seg);
    endtask

    // Four SHOW cycles followed by the single BLANK cycle.
    task automatic run_digit(input string tag, input logic [5:0] dig, input logic [7:0] seg);
        repeat (SCAN_DIV) step(tag, dig, seg);
        step({tag, "_blank"}, 6'h3F, 8'hFF);
    endtask

    task automatic set_leds(input logic [3:0] d5, d4, d3, d2, d1, d0);
        led_5 = d5; led_4 = d4; led_3 = d3; led_2 = d2; led_1 = d1; led_0 = d0;
    endtask

    initial begin
        // Reset with random inputs present
        set_leds(4'($urandom), 4'($urandom), 4'($urandom),
                 4'($urandom), 4'($urandom), 4'($urandom));
        ovf = 1'($urandom);
        repeat (2) @(negedge clock);
        check_out("reset", 6'h3F, 8'hFF);
        check_dv("reset_dv", 1'b0);

        // Release and capture 654321 on the first edge; that edge still shows hold=0
        ovf = 1'b0;
        set_leds(4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1);
        latch = 1'b1;
        clear = 1'b0;
        step("first_show", 6'h3E, 8'hC0);
        check_dv("dv_set", 1'b1);
        latch = 1'b0;
        repeat (SCAN_DIV - 1) step("d0", 6'h3E, 8'hF9);
        step("d0_blank", 6'h3F, 8'hFF);
        run_digit("d1", 6'h3D, 8'hA4);
        run_digit("d2", 6'h3B, 8'hB0);
        run_digit("d3_dp", 6'h37, 8'h19);
        run_digit("d4", 6'h2F, 8'h92);
        run_digit("d5", 6'h1F, 8'h82);

        // Wrap to digit 0, then capture led_0=7 and led_2=A during its cnt=2 cycle
        step("wrap_c0", 6'h3E, 8'hF9);
        step("wrap_c1", 6'h3E, 8'hF9);
        led_0 = 4'd7;
        led_2 = 4'hA;
        latch = 1'b1;
        step("cap_c2", 6'h3E, 8'hF9);
        latch = 1'b0;
        step("cap_c3", 6'h3E, 8'hF8);
        step("cap_blank", 6'h3F, 8'hFF);
        run_digit("cap_d1", 6'h3D, 8'hA4);
        run_digit("bad_bcd_d2", 6'h3B, 8'hBF);
        run_digit("cap_d3", 6'h37, 8'h19);
        run_digit("cap_d4", 6'h2F, 8'h92);
        run_digit("cap_d5", 6'h1F, 8'h82);

        // Overflow: all dashes, digit 3 keeps its dp
        ovf   = 1'b1;
        latch = 1'b1;
        step("ovf_old", 6'h3E, 8'hF8);
        latch = 1'b0;
        repeat (SCAN_DIV - 1) step("ovf_d0", 6'h3E, 8'hBF);
        step("ovf_d0_blank", 6'h3F, 8'hFF);
        run_digit("ovf_d1", 6'h3D, 8'hBF);
        run_digit("ovf_d2", 6'h3B, 8'hBF);
        run_digit("ovf_d3", 6'h37, 8'h3F);
        run_digit("ovf_d4", 6'h2F, 8'hBF);
        run_digit("ovf_d5", 6'h1F, 8'hBF);

        // Overflow clears; latch 000042
        ovf = 1'b0;
        set_leds(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
        latch = 1'b1;
        step("lz_old", 6'h3E, 8'hBF);
        latch = 1'b0;
        repeat (SCAN_DIV - 1) step("lz_d0", 6'h3E, 8'hA4);
        step("lz_d0_blank", 6'h3F, 8'hFF);
        run_digit("lz_d1", 6'h3D, 8'h99);
`ifdef LEADING_ZERO_BLANK_EN
        run_digit("lz_d2", 6'h3B, 8'hFF);
        run_digit("lz_d3", 6'h37, 8'h7F);
        run_digit("lz_d4", 6'h2F, 8'hFF);
        run_digit("lz_d5", 6'h1F, 8'hFF);
`else
        run_digit("lz_d2", 6'h3B, 8'hC0);
        run_digit("lz_d3", 6'h37, 8'h40);
        run_digit("lz_d4", 6'h2F, 8'hC0);
        run_digit("lz_d5", 6'h1F, 8'hC0);
`endif

        // Mid-operation reset: immediate return, restart at digit 0 with hold cleared
        step("pre_rst_c0", 6'h3E, 8'hA4);
        step("pre_rst_c1", 6'h3E, 8'hA4);
        clear = 1'b1;
        #1;
        check_out("mid_reset", 6'h3F, 8'hFF);
        check_dv("mid_reset_dv", 1'b0);
        @(negedge clock);
        clear = 1'b0;
        step("restart_c0", 6'h3E, 8'hC0);
        repeat (SCAN_DIV - 1) step("restart_d0", 6'h3E, 8'hC0);
        step("restart_blank", 6'h3F, 8'hFF);
        check_dv("restart_dv", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
